// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings and condition evaluation for the multicycle control unit
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_ORR   = 4'b0011;
  localparam logic [3:0] ALU_EOR   = 4'b0100;
  localparam logic [3:0] ALU_MUL   = 4'b0101;
  localparam logic [3:0] ALU_UMULL = 4'b0110;
  localparam logic [3:0] ALU_SMULL = 4'b0111;
  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;
  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_DATA   = 2'd1;
  localparam logic [1:0] RES_ALURES = 2'd2;
  localparam logic [3:0] COND_AL = 4'b1110;
  // ARM condition check on {N,Z,C,V}; the 1111 space never executes
  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0: cond_ok = z;
      4'h1: cond_ok = !z;
      4'h2: cond_ok = c;
      4'h3: cond_ok = !c;
      4'h4: cond_ok = n;
      4'h5: cond_ok = !n;
      4'h6: cond_ok = v;
      4'h7: cond_ok = !v;
      4'h8: cond_ok = c && !z;
      4'h9: cond_ok = !c || z;
      4'ha: cond_ok = n == v;
      4'hb: cond_ok = n != v;
      4'hc: cond_ok = !z && (n == v);
      4'hd: cond_ok = z || (n != v);
      COND_AL: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/mc_cond_unit.sv
// mc_cond_unit: NZCV register, condition latch and gated flag update
module mc_cond_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       cond_latch,
  input  logic       flag_wr,
  input  logic       cv_wr,
  output logic       cond_ex,
  output logic [3:0] flags
);
  // condition sampled in DECODE against the previous instruction's flags; flags written only when the instruction executes
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      flags   <= '0;
      cond_ex <= 1'b0;
    end else begin
      if (cond_latch) cond_ex <= cond_ok(cond, flags);
      if (flag_wr && cond_ex) begin
        flags[3:2] <= alu_flags[3:2];
        if (cv_wr) flags[1:0] <= alu_flags[1:0];
      end
    end
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle main controller with instruction decode and multiply support
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH,
  parameter bit     EN_LONGMUL  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [3:0]  ALUControl,
  output logic        opMul,
  output logic        IsLongMul,
  output logic [3:0]  State,
  output logic [3:0]  Flags
);
  state_t state, next;
  logic [1:0] op;
  logic [3:0] cmd, rd, alu_dp;
  logic mul_pat, is_long, is_mul, is_test, cv_cmd, cond_ex;
  logic pc_w, reg_w, ir_w, mem_w, long_w;
  logic unused_bits;
  assign op      = Instr[27:26];
  assign cmd     = Instr[24:21];
  assign mul_pat = op == 2'b00 && Instr[7:4] == 4'b1001 && (Instr[27:22] == 6'b000000 || Instr[27:23] == 5'b00001);
  assign is_long = mul_pat && Instr[23];
  assign is_mul  = mul_pat && (!Instr[23] || EN_LONGMUL);
  assign is_test = !is_mul && (cmd == 4'b1010 || cmd == 4'b1000);
  assign cv_cmd  = !is_mul && (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010);
  assign rd      = is_mul ? Instr[19:16] : Instr[15:12];
  assign alu_dp  = is_mul ? (is_long ? (Instr[22] ? ALU_SMULL : ALU_UMULL) : ALU_MUL) :
                   cmd == 4'b0100 ? ALU_ADD :
                   (cmd == 4'b0010 || cmd == 4'b1010) ? ALU_SUB :
                   (cmd == 4'b0000 || cmd == 4'b1000) ? ALU_AND :
                   cmd == 4'b1100 ? ALU_ORR :
                   cmd == 4'b0001 ? ALU_EOR : ALU_ADD;
  assign unused_bits = ^{Instr[11:8], Instr[3:0]};
  mc_cond_unit u_cond (
    .clk        (clk),
    .reset      (reset),
    .cond       (Instr[31:28]),
    .alu_flags  (ALUFlags),
    .cond_latch (state == DECODE),
    .flag_wr    ((state == EXECUTER || state == EXECUTEI) && Instr[20]),
    .cv_wr      (cv_cmd),
    .cond_ex    (cond_ex),
    .flags      (Flags)
  );
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= RESET_STATE;
    else state <= next;
  // next-state decode; unsupported encodings (incl. disabled long multiply) fall back to FETCH
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:              next = DECODE;
      DECODE:             next = op == 2'b01 ? MEMADR : is_mul ? EXECUTER : mul_pat ? FETCH :
                                 op == 2'b00 ? (Instr[25] ? EXECUTEI : EXECUTER) :
                                 op == 2'b10 ? BRANCH : FETCH;
      MEMADR:             next = Instr[20] ? MEMREAD : MEMWRITE;
      MEMREAD:            next = MEMWB;
      EXECUTER, EXECUTEI: next = ALUWB;
      default:            next = FETCH;
    endcase
  end
  // per-state datapath controls; writes to R15 also redirect the PC
  always_comb begin
    pc_w = 1'b0; reg_w = 1'b0; ir_w = 1'b0; mem_w = 1'b0; long_w = 1'b0;
    AdrSrc = 1'b0; ALUSrcA = 1'b0; ALUSrcB = SRCB_REG; ResultSrc = RES_ALUOUT;
    RegSrc = 2'b00; ALUControl = ALU_ADD;
    case (state)
      FETCH: begin
        ir_w = 1'b1; pc_w = 1'b1; ALUSrcA = 1'b1; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURES;
      end
      DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURES;
      end
      MEMADR: begin
        ALUSrcB = SRCB_IMM; ALUControl = Instr[23] ? ALU_ADD : ALU_SUB;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA; reg_w = cond_ex; pc_w = cond_ex && rd == 4'd15;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1; RegSrc = 2'b10; mem_w = cond_ex;
      end
      EXECUTER: begin
        ALUControl = alu_dp; long_w = is_long && is_mul;
      end
      EXECUTEI: begin
        ALUSrcB = SRCB_IMM; ALUControl = alu_dp;
      end
      ALUWB: begin
        ALUControl = alu_dp; reg_w = cond_ex && !is_test; pc_w = reg_w && rd == 4'd15;
        long_w = is_long && is_mul && cond_ex;
      end
      BRANCH: begin
        RegSrc = 2'b01; ALUSrcB = SRCB_IMM; ResultSrc = RES_ALURES; pc_w = cond_ex;
      end
      default: ;
    endcase
  end
  assign PCWrite   = reset && pc_w;
  assign RegWrite  = reset && reg_w;
  assign IRWrite   = reset && ir_w;
  assign MemWrite  = reset && mem_w;
  assign IsLongMul = reset && long_w;
  assign opMul     = is_mul && (state == DECODE || state == EXECUTER || state == ALUWB);
  assign ImmSrc    = Instr[27:26];
  assign State     = state;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed instruction walk-through of the multicycle controller
module tb_mc_control_fsm;
  logic clk, reset;
  logic [31:0] Instr;
  logic [3:0] ALUFlags;
  logic PCWrite, RegWrite, IRWrite, MemWrite, AdrSrc, ALUSrcA, opMul, IsLongMul;
  logic [1:0] RegSrc, ALUSrcB, ResultSrc, ImmSrc;
  logic [3:0] ALUControl, State, Flags;
  int n_cmp = 0;
  int n_err = 0;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .RegSrc(RegSrc), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .opMul(opMul),
    .IsLongMul(IsLongMul), .State(State), .Flags(Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; Instr = 32'h0; ALUFlags = 4'h0;
    step(); step();
    chk("rst_state", State, 0);
    chk("rst_flags", Flags, 0);
    chk("rst_pcw", PCWrite, 0);
    chk("rst_irw", IRWrite, 0);
    chk("rst_regw", RegWrite, 0);
    chk("rst_memw", MemWrite, 0);
    reset = 1'b1; #1;
    chk("fetch_irw", IRWrite, 1);
    chk("fetch_pcw", PCWrite, 1);
    chk("fetch_srcb", ALUSrcB, 2);
    // LDR aborted by reset in MEMADR
    Instr = 32'hE5910004;
    step(); chk("ldr0_decode", State, 1);
    step(); chk("ldr0_memadr", State, 2);
    chk("ldr0_srcb", ALUSrcB, 1);
    chk("ldr0_alu", ALUControl, 0);
    reset = 1'b0; #1;
    chk("mid_rst_state", State, 0);
    chk("mid_rst_irw", IRWrite, 0);
    chk("mid_rst_pcw", PCWrite, 0);
    chk("mid_rst_flags", Flags, 0);
    step(); reset = 1'b1; #1;
    chk("rel_state", State, 0);
    chk("rel_irw", IRWrite, 1);
    // LDR full run
    step(); chk("ldr_decode", State, 1);
    step(); chk("ldr_memadr", State, 2);
    step(); chk("ldr_memread", State, 3);
    chk("ldr_adrsrc", AdrSrc, 1);
    chk("ldr_rd_res", ResultSrc, 0);
    step(); chk("ldr_memwb", State, 4);
    chk("ldr_wb_res", ResultSrc, 1);
    chk("ldr_wb_regw", RegWrite, 1);
    chk("ldr_wb_pcw", PCWrite, 0);
    step(); chk("ldr_done", State, 0);
    // STR
    Instr = 32'hE5810004;
    step(); step(); chk("str_memadr", State, 2);
    step(); chk("str_memwrite", State, 5);
    chk("str_memw", MemWrite, 1);
    chk("str_regsrc", RegSrc, 2'b10);
    chk("str_regw", RegWrite, 0);
    step(); chk("str_done", State, 0);
    // ADD R1,R2,R3
    Instr = 32'hE0821003;
    step(); chk("add_decode", State, 1);
    chk("add_dec_srca", ALUSrcA, 1);
    chk("add_dec_regw", RegWrite, 0);
    step(); chk("add_exec", State, 6);
    chk("add_srcb", ALUSrcB, 0);
    chk("add_alu", ALUControl, 0);
    chk("add_exec_regw", RegWrite, 0);
    step(); chk("add_aluwb", State, 8);
    chk("add_wb_regw", RegWrite, 1);
    chk("add_wb_pcw", PCWrite, 0);
    step(); chk("add_done", State, 0);
    chk("add_fetch_regw", RegWrite, 0);
    // SUBS sets Z
    Instr = 32'hE0500000; ALUFlags = 4'b0100;
    step(); step(); chk("subs_alu", ALUControl, 1);
    step(); chk("subs_flags", Flags, 4'b0100);
    chk("subs_regw", RegWrite, 1);
    step();
    // ADDEQ executes
    Instr = 32'h00821003; ALUFlags = 4'b0000;
    step(); step(); step(); chk("addeq_state", State, 8);
    chk("addeq_regw", RegWrite, 1);
    step();
    // ADDNE skipped
    Instr = 32'h10821003;
    step(); step(); step(); chk("addne_regw", RegWrite, 0);
    chk("addne_flags", Flags, 4'b0100);
    step();
    // B
    Instr = 32'hEAFFFFFE;
    step(); step(); chk("b_state", State, 9);
    chk("b_pcw", PCWrite, 1);
    chk("b_regsrc", RegSrc, 2'b01);
    chk("b_srcb", ALUSrcB, 1);
    chk("b_res", ResultSrc, 2);
    step(); chk("b_done", State, 0);
    // BNE with Z=1
    Instr = 32'h1AFFFFFE;
    step(); step(); chk("bne_state", State, 9);
    chk("bne_pcw", PCWrite, 0);
    step();
    // UMULL R4,R5,R2,R3
    Instr = 32'hE0854392;
    step(); chk("umull_dec_opmul", opMul, 1);
    step(); chk("umull_exec", State, 6);
    chk("umull_alu", ALUControl, 4'b0110);
    chk("umull_exec_long", IsLongMul, 1);
    chk("umull_exec_opmul", opMul, 1);
    step(); chk("umull_wb_long", IsLongMul, 1);
    chk("umull_wb_regw", RegWrite, 1);
    chk("umull_wb_pcw", PCWrite, 0);
    step(); chk("umull_fetch_opmul", opMul, 0);
    // CMP: no writeback, CV updated
    Instr = 32'hE1500000; ALUFlags = 4'b0010;
    step(); step(); chk("cmp_alu", ALUControl, 1);
    step(); chk("cmp_regw", RegWrite, 0);
    chk("cmp_flags", Flags, 4'b0010);
    step();
    // ANDS: NZ only, CV kept
    Instr = 32'hE0100000; ALUFlags = 4'b1011;
    step(); step(); chk("ands_alu", ALUControl, 2);
    step(); chk("ands_flags", Flags, 4'b1010);
    step();
    // ADD into R15 redirects the PC
    Instr = 32'hE082F003;
    step(); step(); step(); chk("addpc_regw", RegWrite, 1);
    chk("addpc_pcw", PCWrite, 1);
    step();
    // cond 1111 never executes
    Instr = 32'hF0821003;
    step(); step(); step(); chk("nv_regw", RegWrite, 0);
    chk("nv_pcw", PCWrite, 0);
    step();
    // op 11 is a NOP
    Instr = 32'hEF000000;
    step(); chk("nop_decode", State, 1);
    step(); chk("nop_back", State, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle control unit that sits directly upstream of the datapath.
- Consumes the latched instruction word and the ALU flags; drives every datapath control signal plus the memory write enable.
- Contains the main state machine, instruction/ALU decode, the NZCV flags register and per-instruction condition evaluation, including multiply (MUL/UMULL/SMULL) support.

Parameters:
- RESET_STATE, 4'd0 (FETCH), state entered on reset.
- EN_LONGMUL, 1, when 0, UMULL/SMULL decode as unsupported (NOP).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- Instr  in  32  instruction register contents from the datapath.
- ALUFlags  in  4  {N,Z,C,V} from the ALU, same cycle.
- PCWrite, RegWrite, IRWrite, MemWrite, AdrSrc, ALUSrcA  out  1 each  datapath/memory controls.
- RegSrc, ALUSrcB, ResultSrc, ImmSrc  out  2 each  datapath mux selects.
- ALUControl  out  4  ALU operation code.
- opMul  out  1  multiply register-field remap.
- IsLongMul  out  1  64-bit result capture and second-register write.
- State  out  4  current FSM state (visualisation).
- Flags  out  4  architectural NZCV register (visualisation).

Behaviour:
- Reset (reset=0, async):
  - State=FETCH; Flags=0; CondExLatch=0.
  - PCWrite, RegWrite, IRWrite, MemWrite and IsLongMul are forced to 0 while reset is low.
  - Reset mid-instruction abandons the instruction; the first rising edge after release runs FETCH.
- Decoded mux encodings:
  - AdrSrc: 0=PC, 1=Result.
  - ALUSrcA: 0=A, 1=PC.
  - ALUSrcB: 0=reg, 1=ExtImm, 2=4.
  - ResultSrc: 0=ALUOut, 1=Data, 2=ALUResult.
  - RegSrc[0]: 1 selects R15 for RA1. RegSrc[1]: 1 selects Rd for RA2 (STR).
  - ImmSrc = Instr[27:26].
- States and outputs:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=2, ADD, ResultSrc=2, PCWrite=1 (unconditional) -> DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=2, ADD, ResultSrc=2. Evaluates the condition against Flags and latches CondEx.
    - Instr[27:26]=01 -> MEMADR.
    - 00 with multiply pattern (Instr[27:22]=000000 or 000010, Instr[7:4]=1001) -> EXECUTER with opMul=1.
    - 00 with I=0 -> EXECUTER; 00 with I=1 -> EXECUTEI.
    - 10 -> BRANCH.
    - Else -> FETCH (NOP).
  - MEMADR: ALUSrcA=0, ALUSrcB=1; ADD if U=1, SUB if U=0. L=1 -> MEMREAD; L=0 -> MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=0 -> MEMWB.
  - MEMWB: ResultSrc=1, RegWrite=CondEx -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=0, RegSrc[1]=1, MemWrite=CondEx -> FETCH.
  - EXECUTER: ALUSrcA=0, ALUSrcB=0, decoded ALUControl -> ALUWB.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=1 -> ALUWB.
  - ALUWB: ResultSrc=0; RegWrite=CondEx unless CMP/TST -> FETCH.
  - BRANCH: RegSrc[0]=1, ALUSrcA=0, ALUSrcB=1, ADD, ResultSrc=2, PCWrite=CondEx -> FETCH.
- PC-relative writeback: if Rd=15 and RegWrite would assert in ALUWB/MEMWB, PCWrite=CondEx also asserts.
- ALUControl codes: ADD 0000, SUB 0001, AND 0010, ORR 0011, EOR 0100, MUL 0101, UMULL 0110, SMULL 0111. Data-processing cmd 0100/0010/0000/1100/0001/1010 map to ADD/SUB/AND/ORR/EOR/SUB(CMP).
- Multiply:
  - opMul=1 in DECODE through ALUWB for any multiply.
  - IsLongMul=1 in EXECUTER and ALUWB (gated by CondEx in ALUWB) for UMULL/SMULL, writing RdLo and RdHi in the same ALUWB cycle.
- Flags register:
  - Written on the ALUWB entry edge (end of EXECUTE*) when S=1 and CondEx=1.
  - NZ are always written; CV only for ADD/SUB/CMP. Multiplies with S=1 write NZ only.
  - Flags used in DECODE are those of the previous instruction; there is no bypass.
- Condition codes: all 15 ARM conds; 1110 is always true. 1111 is treated as false (NOP).

Decomposition:
- Package mc_ctrl_pkg: state encodings (FETCH=0 … BRANCH=9), ALUControl codes, cond-code constants, mux-select constants.
- Sub-module mc_cond_unit: Flags register, condition evaluation, CondEx latch, flag-write gating.

Test Plan:
- Reset low during MEMADR of LDR, then release -> State=0, Flags=0, all write enables 0 while low; FETCH on the next edge.
- E0821003 (ADD R1,R2,R3) -> states 0,1,6,8,0; ALUSrcB=0, ALUControl=0000 in EXECUTER; RegWrite=1 only in ALUWB.
- E5910004 (LDR) -> 0,1,2,3,4,0 with ResultSrc=1 and RegWrite in MEMWB. E5810004 (STR) -> MemWrite=1 and RegSrc=2'b10 in MEMWRITE.
- E0500000 (SUBS, ALUFlags=0100) -> Flags=0100. Then 00821003 (ADDEQ) -> RegWrite=1. Then 10821003 (ADDNE) -> RegWrite=0 in ALUWB.
- EAFFFFFE (B) -> 0,1,9,0 with PCWrite=1 in BRANCH. 1AFFFFFE (BNE) with Z=1 -> PCWrite=0.
- E0854392 (UMULL R4,R5,R2,R3) -> opMul=1, ALUControl=0110, IsLongMul=1 in EXECUTER and ALUWB, RegWrite=1 in ALUWB.
